// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives the select lines of a 4:1 mux tree through channels 0..3. Each
// channel is held for SETTLE_CYCLES cycles and then sampled for one cycle.
// The four samples are reassembled into a registered 4-bit word.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       level; starts a scan when idle, ignored while busy
//   continuous  checked in DONE; 1 = start the next scan immediately
//   mux_y       Y output of the mux tree
//   sel_1       low select  (= ch[0])
//   sel_2       high select (= ch[1])
//   data        last complete scan; data[i] = mux_y sampled on channel i
//   data_valid  one-cycle pulse when data updates
//   changed     one-cycle pulse with data_valid when data differs from before
//   busy        high in every state except IDLE
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_y,
    output logic       sel_1,
    output logic       sel_2,
    output logic [3:0] data,
    output logic       data_valid,
    output logic       changed,
    output logic       busy
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || (2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_param
            $error("mux_scan_sequencer: SETTLE_CYCLES must be 1..15 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       shadow_q;   // channels 0..2; channel 3 goes straight into data
    logic [3:0]       data_q;
    logic             data_valid_q;
    logic             changed_q;

    // Complete word as it stands during the final SAMPLE cycle.
    logic [3:0] word_d;
    assign word_d = {mux_y, shadow_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ch_q         <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 3'd0;
            data_q       <= 4'd0;
            data_valid_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            changed_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ch_q <= 2'd0;
                    if (start) begin
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (ch_q == 2'd3) begin
                        // Publish here so the pulse lines up with the DONE cycle.
                        data_q       <= word_d;
                        data_valid_q <= 1'b1;
                        changed_q    <= (word_d != data_q);
                        state_q      <= S_DONE;
                    end else begin
                        case (ch_q)
                            2'd0:    shadow_q[0] <= mux_y;
                            2'd1:    shadow_q[1] <= mux_y;
                            default: shadow_q[2] <= mux_y;
                        endcase
                        ch_q    <= ch_q + 2'd1;
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    ch_q <= 2'd0;
                    if (continuous) begin
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel_1      = ch_q[0];
    assign sel_2      = ch_q[1];
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign changed    = changed_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer. Two instances: "a" with SETTLE_CYCLES=2
// and "b" with SETTLE_CYCLES=4 (glitching mux). A timeline model predicts
// every output from the number of edges since the scan began.
module tb_mux_scan_sequencer;

    localparam int S_A = 2;
    localparam int S_B = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_v = 2'b00;
    logic [1:0] cont_v = 2'b00;
    logic [3:0] x_a = 4'd0;
    logic [3:0] x_b = 4'd0;
    logic       glitch_en = 1'b0;
    int         age_b = 99;
    int         glitch_cycles = 0;
    logic [1:0] last_sel_b = 2'd0;

    logic       sel1_a, sel2_a, dv_a, chg_a, busy_a, mux_y_a;
    logic       sel1_b, sel2_b, dv_b, chg_b, busy_b, mux_y_b;
    logic [3:0] data_a, data_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_y_a = x_a[{sel2_a, sel1_a}];
    // Instance b sees a mux output that is wrong for the first 3 cycles after a select change.
    assign mux_y_b = x_b[{sel2_b, sel1_b}] ^ (glitch_en && (age_b < 3));

    mux_scan_sequencer #(.SETTLE_CYCLES(S_A), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .continuous(cont_v[0]),
        .mux_y(mux_y_a), .sel_1(sel1_a), .sel_2(sel2_a), .data(data_a),
        .data_valid(dv_a), .changed(chg_a), .busy(busy_a)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(S_B), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .continuous(cont_v[1]),
        .mux_y(mux_y_b), .sel_1(sel1_b), .sel_2(sel2_b), .data(data_b),
        .data_valid(dv_b), .changed(chg_b), .busy(busy_b)
    );

    // Age of the current select value on instance b, in cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if ({sel2_b, sel1_b} != last_sel_b) begin
                age_b = 0;
                last_sel_b = {sel2_b, sel1_b};
            end else if (age_b < 99) begin
                age_b++;
            end
            if (glitch_en && age_b < 3 && busy_b) glitch_cycles++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t_m = edges since the edge that began the scan. Channel c occupies
    // t in [c*P, (c+1)*P) with P = SETTLE+1 and is sampled at edge (c+1)*P.
    // t = 4P is the data_valid cycle; the following edge ends the scan.
    bit         act_m[2];
    int         t_m[2];
    logic [3:0] samp_m[2];
    logic [3:0] data_m[2];
    logic       dv_m[2];
    logic       chg_m[2];
    logic       snap_start[2];
    logic       snap_cont[2];
    logic       snap_y[2];

    function automatic int settle_of(input int i);
        return (i == 0) ? S_A : S_B;
    endfunction

    function automatic int exp_ch(input int i);
        int p;
        p = settle_of(i) + 1;
        if (!act_m[i]) return 0;
        if (t_m[i] < 4 * p) return t_m[i] / p;
        return 3;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            act_m[i] = 1'b0; t_m[i] = 0; samp_m[i] = 4'd0; data_m[i] = 4'd0;
            dv_m[i] = 1'b0; chg_m[i] = 1'b0;
            snap_start[i] = 1'b0; snap_cont[i] = 1'b0; snap_y[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act_m[i] = 1'b0; t_m[i] = 0; samp_m[i] = 4'd0; data_m[i] = 4'd0;
                    dv_m[i] = 1'b0; chg_m[i] = 1'b0;
                end else begin
                    int p;
                    int tn;
                    p = settle_of(i) + 1;
                    dv_m[i] = 1'b0;
                    chg_m[i] = 1'b0;
                    if (!act_m[i]) begin
                        if (snap_start[i]) begin
                            act_m[i] = 1'b1;
                            t_m[i] = 0;
                        end
                    end else begin
                        tn = t_m[i] + 1;
                        if (tn == 4 * p + 1) begin
                            t_m[i] = 0;
                            if (!snap_cont[i]) act_m[i] = 1'b0;
                        end else begin
                            t_m[i] = tn;
                            if (tn % p == 0) samp_m[i][tn / p - 1] = snap_y[i];
                            if (tn == 4 * p) begin
                                chg_m[i] = (samp_m[i] != data_m[i]);
                                data_m[i] = samp_m[i];
                                dv_m[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [1:0] sel, input logic b,
                            input logic [3:0] d, input logic dv, input logic c);
        string pfx;
        pfx = (i == 0) ? "a" : "b";
        chk({pfx, ".sel"}, 32'(sel), 32'(exp_ch(i)));
        chk({pfx, ".busy"}, 32'(b), 32'(act_m[i]));
        chk({pfx, ".data"}, 32'(d), 32'(data_m[i]));
        chk({pfx, ".data_valid"}, 32'(dv), 32'(dv_m[i]));
        chk({pfx, ".changed"}, 32'(c), 32'(chg_m[i]));
    endtask

    // Per-cycle comparison, then capture of the inputs the next edge will see.
    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, {sel2_a, sel1_a}, busy_a, data_a, dv_a, chg_a);
            cmp_inst(1, {sel2_b, sel1_b}, busy_b, data_b, dv_b, chg_b);
            snap_start[0] = start_v[0]; snap_start[1] = start_v[1];
            snap_cont[0]  = cont_v[0];  snap_cont[1]  = cont_v[1];
            snap_y[0]     = mux_y_a;    snap_y[1]     = mux_y_b;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; the edge inside is the one that accepts start.
    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        @(posedge clk);
        #2;
        start_v[i] = 1'b0;
    endtask

    task automatic wait_dv(input int i, input int limit, output int n);
        n = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if ((i == 0) ? dv_a : dv_b) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int noisy;

        // Reset with random inputs
        repeat (5) begin
            tick();
            start_v = 2'($urandom);
            cont_v  = 2'($urandom);
            x_a     = 4'($urandom);
        end
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.sel", 32'({sel2_a, sel1_a}), 32'd0);
        chk("rst.data", 32'(data_a), 32'd0);
        start_v = 2'b00;
        cont_v  = 2'b00;
        tick();
        rst_n = 1'b1;
        noisy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a || dv_a || sel1_a || sel2_a || busy_b || dv_b) noisy++;
        end
        chk("idle.quiet", 32'(noisy), 32'd0);

        // Single scan, X=1010
        tick();
        x_a = 4'b1010;
        pulse_start(0);
        n = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k < 12) chk("scan.sel_seq", 32'({sel2_a, sel1_a}), 32'(k / 3));
            if (dv_a) begin
                n = k;
                break;
            end
        end
        chk("scan.latency", 32'(n), 32'd12);
        chk("scan.data", 32'(data_a), 32'b1010);
        chk("scan.changed", 32'(chg_a), 32'd1);
        @(negedge clk);
        chk("scan.busy_drop", 32'(busy_a), 32'd0);

        // Continuous, X=0110 then 0111
        tick();
        x_a = 4'b0110;
        cont_v[0] = 1'b1;
        pulse_start(0);
        wait_dv(0, 40, n);
        chk("cont.first_latency", 32'(n), 32'd12);
        chk("cont.first_data", 32'(data_a), 32'b0110);
        chk("cont.first_changed", 32'(chg_a), 32'd1);
        for (int p = 0; p < 2; p++) begin
            wait_dv(0, 40, n);
            chk("cont.period", 32'(n), 32'd12);
            chk("cont.same_data", 32'(data_a), 32'b0110);
            chk("cont.unchanged", 32'(chg_a), 32'd0);
        end
        tick();
        x_a = 4'b0111;
        wait_dv(0, 40, n);
        chk("cont.new_period", 32'(n), 32'd12);
        chk("cont.new_data", 32'(data_a), 32'b0111);
        chk("cont.new_changed", 32'(chg_a), 32'd1);
        tick();
        cont_v[0] = 1'b0;
        wait_dv(0, 40, n);
        chk("cont.last_period", 32'(n), 32'd12);
        @(negedge clk);
        chk("cont.stops", 32'(busy_a), 32'd0);

        // start during a scan is ignored
        tick();
        x_a = 4'b0101;
        fork
            begin
                repeat (5) @(posedge clk);
                #2;
                start_v[0] = 1'b1;
                @(posedge clk);
                #2;
                start_v[0] = 1'b0;
            end
        join_none
        pulse_start(0);
        wait_dv(0, 40, n);
        chk("busy_start.latency", 32'(n), 32'd12);
        chk("busy_start.data", 32'(data_a), 32'b0101);
        @(negedge clk);
        chk("busy_start.no_restart", 32'(busy_a), 32'd0);

        // Async reset in cycle 7 of a scan
        tick();
        x_a = 4'b1111;
        pulse_start(0);
        repeat (8) @(negedge clk);
        chk("areset.pre_busy", 32'(busy_a), 32'd1);
        chk("areset.pre_sel", 32'({sel2_a, sel1_a}), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.busy", 32'(busy_a), 32'd0);
        chk("areset.sel", 32'({sel2_a, sel1_a}), 32'd0);
        chk("areset.data", 32'(data_a), 32'd0);
        chk("areset.dv", 32'(dv_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(0);
        wait_dv(0, 40, n);
        chk("areset.rescan_latency", 32'(n), 32'd12);
        chk("areset.rescan_data", 32'(data_a), 32'b1111);
        chk("areset.rescan_changed", 32'(chg_a), 32'd1);

        // Settle window on instance b with glitching mux_y
        tick();
        x_b = 4'b1001;
        glitch_en = 1'b1;
        pulse_start(1);
        wait_dv(1, 60, n);
        chk("glitch.latency", 32'(n), 32'd20);
        chk("glitch.data", 32'(data_b), 32'b1001);
        chk("glitch.changed", 32'(chg_b), 32'd1);
        chk("glitch.applied", 32'(glitch_cycles > 0), 32'd1);

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            tick();
            start_v[0] = ($urandom_range(0, 7) == 0);
            start_v[1] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) cont_v[0] = ~cont_v[0];
            if ($urandom_range(0, 39) == 0) cont_v[1] = ~cont_v[1];
            if ($urandom_range(0, 29) == 0) x_a = 4'($urandom);
            if ($urandom_range(0, 29) == 0) x_b = 4'($urandom);
            if ($urandom_range(0, 49) == 0) glitch_en = ~glitch_en;
        end
        start_v = 2'b00;
        cont_v  = 2'b00;
        repeat (60) tick();
        chk("drain.idle_a", 32'(busy_a), 32'd0);
        chk("drain.idle_b", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the team's 4:1 mux tree (4-bit X, selects sel_1/sel_2, 1-bit Y).
- Walks the mux select lines through all four channels and waits a programmable settle time after each select change.
- Samples the mux output Y per channel and reassembles it into a registered 4-bit word with a valid pulse and a change flag.
- Provides single-shot and continuous scanning, and feeds downstream display/compare logic.

Parameters:
- SETTLE_CYCLES, 2: cycles held on each channel before sampling; legal range 1..15. A value of 0 is illegal and is flagged by an elaboration-time check.
- CNT_W, 4: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level, sampled on the clock. Starts a scan when IDLE; ignored otherwise.
- continuous  input  1  sampled in DONE. 1 = begin the next scan immediately.
- mux_y  input  1  Y output of the 4:1 mux tree.
- sel_1  output  1  low select to the mux tree, = ch[0]; picks within a pair.
- sel_2  output  1  high select to the mux tree, = ch[1]; picks the pair.
- data  output  4  last complete scan; data[i] = mux_y sampled with {sel_2,sel_1}=i.
- data_valid  output  1  one-cycle pulse when data updates.
- changed  output  1  one-cycle pulse, coincident with data_valid, when the new data differs from the previous data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ch=0, cnt=0, shadow=0.
  - data=0, data_valid=0, changed=0, busy=0, sel_1=sel_2=0.
- All outputs are registered or decoded directly from registered state; there is no combinational path from inputs to outputs.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - ch held at 0.
  - start=1 -> cnt=0, go SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 -> go SAMPLE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - shadow[ch] <= mux_y.
  - If ch==3 -> go DONE. Otherwise ch <= ch+1, cnt=0, go SETTLE.
- DONE (1 cycle):
  - data <= shadow, with bit 3 taken from the value captured in the final SAMPLE.
  - data_valid=1.
  - changed=1 iff the new data != the previous data.
  - ch <= 0.
  - continuous=1 -> cnt=0, go SETTLE. Otherwise go IDLE.
- Channel order is fixed: 0,1,2,3. ch wraps 3->0 only via DONE.
- Latency:
  - Each channel takes SETTLE_CYCLES+1 cycles.
  - data_valid is high in the cycle after the 4*(SETTLE_CYCLES+1)-th rising edge following the edge that accepted start; that is 12 edges for the default.
  - In continuous mode, data_valid repeats every 4*(SETTLE_CYCLES+1)+1 cycles.
- data and changed hold between pulses. changed drops to 0 whenever data_valid is 0.
- start while busy is ignored; no queuing.
- start held high in IDLE after a single-shot scan starts a new scan on the next edge.
- continuous deasserted mid-scan: the current scan completes, then the block goes IDLE.
- Reset mid-scan:
  - Immediate return to the reset values; the partial shadow is discarded.
  - The first post-reset scan compares against 0 for changed.
- sel_1/sel_2 change only on the SAMPLE->SETTLE and DONE transitions, so mux_y always has the full settle window before sampling.

Test Plan:
- Reset then idle: rst_n=0 with random inputs -> all outputs 0. After release with start=0 for 20 cycles -> busy=0, sel=00, no data_valid.
- Single scan, SETTLE_CYCLES=2, mux X=4'b1010 (model mux_y = X[{sel_2,sel_1}]), start pulsed one cycle:
  - sel sequence 00,01,10,11 with 3 cycles each.
  - data_valid pulses 12 edges after the start edge with data=4'b1010 and changed=1.
  - busy drops the next cycle.
- Continuous, X=4'b0110 held: repeated data_valid every 13 cycles with data=4'b0110. changed=1 only on the first pulse; change X to 4'b0111 -> the next pulse has changed=1.
- start during a scan: pulse start in cycle 5 of a scan -> no restart, and data_valid timing is unchanged.
- Async reset at cycle 7 of a scan with X=4'b1111:
  - Outputs clear immediately without waiting for a clock edge.
  - After release, a new start yields data=4'b1111 with changed=1.
- Settle check, SETTLE_CYCLES=4: glitch mux_y only in the first 3 cycles after each select change -> the glitches are not captured in data.
